// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
// Holds the FSM state encoding, mode constants and index wrap helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // k is always below 2*n here, so one subtraction wraps it
  function automatic int arb_wrap(input int k, input int n);
    return (k >= n) ? (k - n) : k;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational N-way picker: fixed (highest index) or
// round-robin (rotate by ptr, lowest set bit, rotate back).
module prio_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [N-1:0] win,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;

  always_comb begin
    rot = '0;
    idx = '0;
    any = |cand;
    for (int j = 0; j < N; j++) begin
      rot[j] = cand[arb_wrap(j + int'(ptr), N)];
    end
    if (mode == ARB_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) idx = W'(i);
      end
    end else begin
      for (int j = N - 1; j >= 0; j--) begin
        if (rot[j]) idx = W'(arb_wrap(j + int'(ptr), N));
      end
    end
    win = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter with grant lock, fixed or
// round-robin arbitration, and bubble-free handover.
module priority_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         valid
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] cand;
  logic [N-1:0] pick_win;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         take;

  // the owner is excluded so a release can regrant on the same edge
  assign cand = req & ~gnt_q;

  prio_pick #(.N(N), .W(W)) u_pick (
    .cand (cand),
    .ptr  (ptr_q),
    .mode (mode),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    case (state_q)
      ARB_IDLE: take = |req;
      ARB_BUSY: begin
        if (!req[idx_q]) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take) begin
      state_d = ARB_BUSY;
      gnt_d   = pick_win;
      idx_d   = pick_idx;
      valid_d = 1'b1;
      ptr_d   = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Bench for priority_arbiter_rr: N=4 and N=3 instances
// against an owner/pointer reference model.
module tb_priority_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] req4;
  logic [2:0] req3;
  logic [3:0] gnt4;
  logic [1:0] idx4;
  logic       valid4;
  logic [2:0] gnt3;
  logic [1:0] idx3;
  logic       valid3;

  int n_chk  = 0;
  int n_pass = 0;

  int own [2];
  int pt  [2];
  int nn  [2] = '{4, 3};

  always #5 clk = ~clk;

  priority_arbiter_rr #(.N(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .req     (req4),
    .mode    (mode),
    .gnt     (gnt4),
    .gnt_idx (idx4),
    .valid   (valid4)
  );

  priority_arbiter_rr #(.N(3)) u_dut3 (
    .clk     (clk),
    .rst     (rst),
    .req     (req3),
    .mode    (mode),
    .gnt     (gnt3),
    .gnt_idx (idx3),
    .valid   (valid3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int arb_ref(input int n, input int c, input int p,
                                 input logic m);
    if (m == 1'b0) begin
      for (int i = n - 1; i >= 0; i--)
        if (((c >> i) & 1) == 1) return i;
    end else begin
      for (int off = 0; off < n; off++)
        if (((c >> ((p + off) % n)) & 1) == 1) return (p + off) % n;
    end
    return -1;
  endfunction

  task automatic upd(input int k, input int r, input logic m, input logic rs);
    int c;
    int w;
    if (rs) begin
      own[k] = -1;
      pt[k]  = 0;
    end else if (own[k] >= 0 && ((r >> own[k]) & 1) == 1) begin
      // owner keeps its grant
    end else begin
      c = r;
      if (own[k] >= 0) c = c & ~(1 << own[k]);
      w = arb_ref(nn[k], c, pt[k], m);
      own[k] = w;
      if (w >= 0) pt[k] = (w + 1) % nn[k];
    end
  endtask

  function automatic int eg(input int k);
    return (own[k] >= 0) ? (1 << own[k]) : 0;
  endfunction

  function automatic int ei(input int k);
    return (own[k] >= 0) ? own[k] : 0;
  endfunction

  task automatic step(input logic [3:0] r4, input logic [2:0] r3,
                      input logic m, input logic rs);
    @(negedge clk);
    req4 = r4;
    req3 = r3;
    mode = m;
    rst  = rs;
    @(posedge clk);
    #1;
    upd(0, int'(r4), m, rs);
    upd(1, int'(r3), m, rs);
    chk("gnt4",   int'(gnt4),   eg(0));
    chk("idx4",   int'(idx4),   ei(0));
    chk("valid4", int'(valid4), int'(own[0] >= 0));
    chk("gnt3",   int'(gnt3),   eg(1));
    chk("idx3",   int'(idx3),   ei(1));
    chk("valid3", int'(valid3), int'(own[1] >= 0));
  endtask

  initial begin
    logic [3:0] r;
    own  = '{-1, -1};
    pt   = '{0, 0};
    rst  = 1'b1;
    mode = 1'b0;
    req4 = '0;
    req3 = '0;

    step(4'b0000, 3'b000, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 3'b000, 1'b0, 1'b0);
    chk("rst_gnt",   int'(gnt4),   0);
    chk("rst_valid", int'(valid4), 0);
    chk("rst_idx",   int'(idx4),   0);

    step(4'b0110, 3'b110, 1'b0, 1'b0);
    chk("fix_gnt", int'(gnt4), 4);
    chk("fix_idx", int'(idx4), 2);
    step(4'b1110, 3'b110, 1'b0, 1'b0);
    chk("lock_gnt", int'(gnt4), 4);
    step(4'b1010, 3'b010, 1'b0, 1'b0);
    chk("regrant_gnt", int'(gnt4), 8);
    chk("regrant_idx", int'(idx4), 3);
    step(4'b0000, 3'b000, 1'b0, 1'b0);

    step(4'b1111, 3'b111, 1'b1, 1'b0);
    chk("rr_first", int'(idx4), 0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 3'b111, 1'b1, 1'b0);
      chk("rr_hold", int'(idx4), i);
      r = 4'b1111 & ~(4'b0001 << i);
      step(r, r[2:0], 1'b1, 1'b0);
      chk("rr_next", int'(idx4), (i + 1) % 4);
      chk("rr_nobubble", int'(valid4), 1);
    end

    step(4'b0000, 3'b000, 1'b1, 1'b1);
    step(4'b0000, 3'b010, 1'b1, 1'b0);
    chk("wrap3_first", int'(idx3), 1);
    step(4'b0000, 3'b001, 1'b1, 1'b0);
    chk("wrap3_idx", int'(idx3), 0);

    step(4'b0010, 3'b010, 1'b0, 1'b0);
    chk("pre_rst_gnt", int'(gnt4), 2);
    step(4'b0010, 3'b010, 1'b0, 1'b1);
    chk("mid_rst_gnt",   int'(gnt4),   0);
    chk("mid_rst_valid", int'(valid4), 0);
    step(4'b0010, 3'b010, 1'b0, 1'b0);
    step(4'b1010, 3'b010, 1'b1, 1'b0);
    chk("mode_flip_hold", int'(gnt4), 2);
    step(4'b1000, 3'b000, 1'b1, 1'b0);
    chk("mode_flip_rel", int'(idx4), 3);

    step(4'b0000, 3'b000, 1'b1, 1'b0);
    chk("empty_valid", int'(valid4), 0);
    step(4'b0001, 3'b001, 1'b1, 1'b0);
    chk("after_idle", int'(gnt4), 1);

    for (int c = 0; c < 600; c++) begin
      logic [3:0] rr4;
      logic [2:0] rr3;
      logic       mm;
      logic       rs;
      rr4 = 4'($urandom);
      rr3 = 3'($urandom);
      mm  = (($urandom % 8) == 0) ? ~mode : mode;
      rs  = ($urandom % 60) == 0;
      step(rr4, rr3, mm, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
